// File: rtl/csr_queue_writer.sv
// csr_queue_writer
//   Write side of the CSR instruction queue. Dispatch pushes decoded CSR
//   instructions through a valid/ready handshake; they are stored in a flat
//   entry array that the CSR issue stage reads directly. The write pointer
//   is published gray-coded; the reader's gray pointer comes back through a
//   2-flop synchronizer and drives full/occupancy.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_Valid_1           dispatch presents an instruction
//   o_Ready_1           queue can accept this cycle (flop-derived only)
//   i_Instruction_113   instruction payload, sampled on accept
//   i_RdGray_5          reader's gray read pointer (asynchronous domain)
//   o_WrGray_5          gray write pointer, straight from a flop
//   o_Entries_1808      entry k at bits [k*INSTR_W +: INSTR_W]
//   o_Full_1            full per the synchronized read pointer
//   o_Count_5           occupancy 0..2^DEPTH_LOG2 per the synchronized pointer
//   o_Overflow_1        sticky: valid seen while full
module csr_queue_writer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int INSTR_W    = 113
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_Valid_1,
    output logic                                o_Ready_1,
    input  logic [INSTR_W-1:0]                  i_Instruction_113,
    input  logic [DEPTH_LOG2:0]                 i_RdGray_5,
    output logic [DEPTH_LOG2:0]                 o_WrGray_5,
    output logic [INSTR_W*(2**DEPTH_LOG2)-1:0]  o_Entries_1808,
    output logic                                o_Full_1,
    output logic [DEPTH_LOG2:0]                 o_Count_5,
    output logic                                o_Overflow_1
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0]            wrBin;
    logic [PW-1:0]            wrGray;
    logic [PW-1:0]            wrBinNext;
    logic [PW-1:0]            rdS1;
    logic [PW-1:0]            rdS2;
    logic [PW-1:0]            rdBin;
    logic [DEPTH_LOG2-1:0]    wrIdx;
    logic [INSTR_W*DEPTH-1:0] entries;
    logic                     overflow;
    logic                     full;
    logic                     accept;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        rdBin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            rdBin[i] = ^(rdS2 >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer;
    // in gray code that is the read pointer with its top two bits inverted.
    assign full      = (wrGray == {~rdS2[PW-1 -: 2], rdS2[PW-3:0]});
    assign accept    = i_Valid_1 & ~full;
    assign wrBinNext = wrBin + ONE;
    assign wrIdx     = wrBin[DEPTH_LOG2-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrBin    <= '0;
            wrGray   <= '0;
            rdS1     <= '0;
            rdS2     <= '0;
            entries  <= '0;
            overflow <= 1'b0;
        end else begin
            rdS1 <= i_RdGray_5;
            rdS2 <= rdS1;
            if (i_Valid_1 && full) begin
                overflow <= 1'b1;
            end
            // Data and pointer move on the same edge so the reader never sees
            // a pointer ahead of its entry.
            if (accept) begin
                entries[int'(wrIdx)*INSTR_W +: INSTR_W] <= i_Instruction_113;
                wrBin  <= wrBinNext;
                wrGray <= wrBinNext ^ (wrBinNext >> 1);
            end
        end
    end

    assign o_Ready_1      = ~full;
    assign o_Full_1       = full;
    assign o_WrGray_5     = wrGray;
    assign o_Count_5      = wrBin - rdBin;
    assign o_Entries_1808 = entries;
    assign o_Overflow_1   = overflow;

endmodule

// File: tb/tb_csr_queue_writer.sv
// tb_csr_queue_writer
//   Directed bench for csr_queue_writer: reset, fill/overflow, drain release,
//   pointer wrap, simultaneous accept and read advance, handshake hold.
module tb_csr_queue_writer;

    localparam int DL = 4;
    localparam int IW = 113;
    localparam int PW = DL + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             vld = 1'b0;
    logic [IW-1:0]    data = '0;
    logic [PW-1:0]    rdGray = '0;
    logic             ready;
    logic             full;
    logic             ovf;
    logic [PW-1:0]    wrGray;
    logic [PW-1:0]    count;
    logic [IW*16-1:0] entries;

    int vectors = 0;
    int miscompares = 0;

    csr_queue_writer #(.DEPTH_LOG2(DL), .INSTR_W(IW)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_Valid_1         (vld),
        .o_Ready_1         (ready),
        .i_Instruction_113 (data),
        .i_RdGray_5        (rdGray),
        .o_WrGray_5        (wrGray),
        .o_Entries_1808    (entries),
        .o_Full_1          (full),
        .o_Count_5         (count),
        .o_Overflow_1      (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] g(input int b);
        logic [PW-1:0] x;
        x = b[PW-1:0];
        return x ^ (x >> 1);
    endfunction

    function automatic logic [IW-1:0] ent(input int k);
        return entries[k*IW +: IW];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] prev;
        logic          sawFull;

        // ---- reset ----
        repeat (3) tick();
        chk("rst_wrgray", wrGray, 0);
        chk("rst_ready",  ready, 1);
        rst = 1'b0;
        tick();

        // five writes, then asynchronous reset mid-stream
        for (int k = 0; k < 5; k++) begin
            vld = 1'b1; data = IW'(32'hA1 + k); tick();
        end
        vld = 1'b0;
        chk("pre_rst_wrgray", wrGray, 5'b00111);
        chk("pre_rst_count",  count, 5);
        rst = 1'b1;
        #1;
        chk("arst_wrgray",  wrGray, 0);
        chk("arst_count",   count, 0);
        chk("arst_full",    full, 0);
        chk("arst_ready",   ready, 1);
        chk("arst_ovf",     ovf, 0);
        chk("arst_entries", {127'b0, |entries}, 0);
        #1;
        rst = 1'b0;
        vld = 1'b1; data = IW'(32'hB0); tick();
        vld = 1'b0;
        chk("post_rst_entry0", ent(0), 'hB0);
        chk("post_rst_entry1", ent(1), 0);
        chk("post_rst_wrgray", wrGray, 5'b00001);

        // ---- fill: 17 back-to-back writes, reader parked at 0 ----
        rst = 1'b1; #1; rst = 1'b0;
        rdGray = '0;
        for (int k = 1; k <= 17; k++) begin
            vld = 1'b1; data = IW'(k); tick();
        end
        chk("fill_count",   count, 16);
        chk("fill_full",    full, 1);
        chk("fill_ready",   ready, 0);
        chk("fill_ovf",     ovf, 1);
        chk("fill_entry0",  ent(0), 1);
        chk("fill_entry1",  ent(1), 2);
        chk("fill_entry15", ent(15), 16);
        chk("fill_wrgray",  wrGray, 5'b11000);

        // ---- drain release: value 17 is still presented ----
        rdGray = 5'b00001;
        tick();
        chk("drain_e1_ready", ready, 0);
        tick();
        chk("drain_e2_ready", ready, 1);
        chk("drain_e2_count", count, 15);
        tick();
        vld = 1'b0;
        chk("drain_entry0", ent(0), 17);
        chk("drain_count",  count, 16);
        chk("drain_full",   full, 1);
        chk("drain_wrgray", wrGray, 5'b11001);

        // ---- wrap: 40 writes, reader 3 behind ----
        rst = 1'b1; #1; rst = 1'b0;
        rdGray = '0;
        sawFull = 1'b0;
        for (int k = 0; k < 40; k++) begin
            prev = wrGray;
            vld = 1'b1; data = IW'(100 + k);
            rdGray = (k >= 3) ? g(k - 3) : '0;
            tick();
            chk("wrap_onebit", $countones(wrGray ^ prev), 1);
            if (full) sawFull = 1'b1;
            if (k == 31) chk("wrap_gray_zero", wrGray, 0);
        end
        vld = 1'b0;
        tick(); tick();
        chk("wrap_nofull", sawFull, 0);
        chk("wrap_entry0", ent(0), 132);
        chk("wrap_entry7", ent(7), 139);
        chk("wrap_entry8", ent(8), 124);
        chk("wrap_wrgray", wrGray, 5'b01100);
        chk("wrap_count",  count, 4);
        chk("wrap_ovf",    ovf, 0);

        // ---- simultaneous accept and read advance at count 15 ----
        rst = 1'b1; #1; rst = 1'b0;
        rdGray = '0;
        for (int k = 1; k <= 15; k++) begin
            vld = 1'b1; data = IW'(32'h200 + k); tick();
        end
        chk("sim_pre_count", count, 15);
        vld = 1'b1; data = IW'(32'h210); tick();
        vld = 1'b0; rdGray = 5'b00001;
        chk("sim_a_count", count, 16);
        chk("sim_a_full",  full, 1);
        tick();
        chk("sim_b_count", count, 16);
        chk("sim_b_full",  full, 1);
        tick();
        chk("sim_c_count",   count, 15);
        chk("sim_c_ready",   ready, 1);
        chk("sim_ovf",       ovf, 0);
        chk("sim_entry15",   ent(15), 'h210);

        // ---- handshake hold: payload held while not ready ----
        vld = 1'b1; data = IW'(32'h300); tick();
        chk("hold_full",   full, 1);
        chk("hold_entry0", ent(0), 'h300);
        data = IW'(32'h3AB);
        repeat (8) tick();
        rdGray = 5'b00011;
        tick();
        chk("hold_e9_ready",  ready, 0);
        chk("hold_e9_entry1", ent(1), 'h202);
        tick();
        chk("hold_e10_ready", ready, 1);
        tick();
        vld = 1'b0;
        chk("hold_entry1", ent(1), 'h3AB);
        chk("hold_entry2", ent(2), 'h203);
        chk("hold_wrgray", wrGray, 5'b11011);
        chk("hold_full2",  full, 1);
        chk("hold_ovf",    ovf, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
